// File: rtl/jtag_pkg.sv
// Shared TAP definitions: 4-bit state encoding and default IR width.
package jtag_pkg;

   localparam int IR_LENGTH_DEFAULT = 5;

   typedef enum logic [3:0] {
      TAP_EX2DR   = 4'h0,
      TAP_EX1DR   = 4'h1,
      TAP_SHDR    = 4'h2,
      TAP_PAUSEDR = 4'h3,
      TAP_SELIR   = 4'h4,
      TAP_UPDDR   = 4'h5,
      TAP_CAPDR   = 4'h6,
      TAP_SELDR   = 4'h7,
      TAP_EX2IR   = 4'h8,
      TAP_EX1IR   = 4'h9,
      TAP_SHIR    = 4'hA,
      TAP_PAUSEIR = 4'hB,
      TAP_RTI     = 4'hC,
      TAP_UPDIR   = 4'hD,
      TAP_CAPIR   = 4'hE,
      TAP_TLR     = 4'hF
   } tap_state_e;

endpackage

// File: rtl/jtag_ir_shifter.sv
// Instruction register: capture/shift chain plus the held (updated) instruction.
module jtag_ir_shifter
   import jtag_pkg::*;
#(
   parameter int                   IR_LENGTH    = IR_LENGTH_DEFAULT,
   parameter logic [IR_LENGTH-1:0] IDCODE_INSTR = IR_LENGTH'(1)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  tap_state_e           state,
   input  logic                 enter_tlr,
   input  logic                 tdi,
   output logic                 shift_lsb,
   output logic [IR_LENGTH-1:0] instruction
);

   logic [IR_LENGTH-1:0] shift_q, shift_d;
   logic [IR_LENGTH-1:0] instr_q, instr_d;

   // Next-value logic: capture loads ...01, shift pulls TDI in at the MSB, update latches.
   always_comb begin
      shift_d = shift_q;
      instr_d = instr_q;
      case (state)
         TAP_CAPIR: shift_d = IR_LENGTH'(1);
         TAP_SHIR:  shift_d = {tdi, shift_q[IR_LENGTH-1:1]};
         TAP_UPDIR: instr_d = shift_q;
         default:   ;
      endcase
      // Any edge that lands in Test-Logic-Reset restores the IDCODE instruction.
      if (enter_tlr) instr_d = IDCODE_INSTR;
   end

   // Register the shifter and the instruction; TRST forces reset values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         shift_q <= '0;
         instr_q <= IDCODE_INSTR;
      end else begin
         shift_q <= shift_d;
         instr_q <= instr_d;
      end
   end

   assign shift_lsb   = shift_q[0];
   assign instruction = instr_q;

endmodule

// File: rtl/jtag_tap_controller.sv
// IEEE 1149.1 TAP controller: state machine, DR strobes, TDO mux and IR.
// Handshake note: there is no valid/ready flow here; every output is a pure
// function of the registered state (plus shifter LSB / chain data for TDO).
module jtag_tap_controller
   import jtag_pkg::*;
#(
   parameter int                   IR_LENGTH    = IR_LENGTH_DEFAULT,
   parameter logic [IR_LENGTH-1:0] IDCODE_INSTR = IR_LENGTH'(1),
   parameter logic [IR_LENGTH-1:0] BYPASS_INSTR = '1
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 io_tms,
   input  logic                 io_tdi,
   output logic                 io_chainOut_capture,
   output logic                 io_chainOut_shift,
   output logic                 io_chainOut_update,
   input  logic                 io_chainIn_data,
   output logic [IR_LENGTH-1:0] io_instruction,
   output logic                 io_tdo,
   output logic                 io_tdo_driven,
   output logic                 io_testLogicReset,
   output logic                 io_bypass_sel,
   output logic [3:0]           io_dbg_state
);

   tap_state_e state_q, state_d;
   logic       ir_lsb;

   // Next-state table: first arm is TMS=1, second TMS=0.
   always_comb begin
      state_d = state_q;
      case (state_q)
         TAP_TLR:     state_d = io_tms ? TAP_TLR   : TAP_RTI;
         TAP_RTI:     state_d = io_tms ? TAP_SELDR : TAP_RTI;
         TAP_SELDR:   state_d = io_tms ? TAP_SELIR : TAP_CAPDR;
         TAP_CAPDR:   state_d = io_tms ? TAP_EX1DR : TAP_SHDR;
         TAP_SHDR:    state_d = io_tms ? TAP_EX1DR : TAP_SHDR;
         TAP_EX1DR:   state_d = io_tms ? TAP_UPDDR : TAP_PAUSEDR;
         TAP_PAUSEDR: state_d = io_tms ? TAP_EX2DR : TAP_PAUSEDR;
         TAP_EX2DR:   state_d = io_tms ? TAP_UPDDR : TAP_SHDR;
         TAP_UPDDR:   state_d = io_tms ? TAP_SELDR : TAP_RTI;
         TAP_SELIR:   state_d = io_tms ? TAP_TLR   : TAP_CAPIR;
         TAP_CAPIR:   state_d = io_tms ? TAP_EX1IR : TAP_SHIR;
         TAP_SHIR:    state_d = io_tms ? TAP_EX1IR : TAP_SHIR;
         TAP_EX1IR:   state_d = io_tms ? TAP_UPDIR : TAP_PAUSEIR;
         TAP_PAUSEIR: state_d = io_tms ? TAP_EX2IR : TAP_PAUSEIR;
         TAP_EX2IR:   state_d = io_tms ? TAP_UPDIR : TAP_SHIR;
         TAP_UPDIR:   state_d = io_tms ? TAP_SELDR : TAP_RTI;
         default:     state_d = TAP_TLR;
      endcase
   end

   // State register; TRST overrides TMS and parks the controller in TLR.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= TAP_TLR;
      else        state_q <= state_d;
   end

   jtag_ir_shifter #(
      .IR_LENGTH    (IR_LENGTH),
      .IDCODE_INSTR (IDCODE_INSTR)
   ) u_ir (
      .clock       (clock),
      .reset       (reset),
      .state       (state_q),
      .enter_tlr   (state_d == TAP_TLR),
      .tdi         (io_tdi),
      .shift_lsb   (ir_lsb),
      .instruction (io_instruction)
   );

   // Strobes and TDO decode straight from the state register; distinct
   // state compares make the three strobes mutually exclusive.
   always_comb begin
      io_chainOut_capture = (state_q == TAP_CAPDR);
      io_chainOut_shift   = (state_q == TAP_SHDR);
      io_chainOut_update  = (state_q == TAP_UPDDR);
      io_testLogicReset   = (state_q == TAP_TLR);
      io_tdo_driven       = (state_q == TAP_SHIR) || (state_q == TAP_SHDR);
      io_tdo              = 1'b0;
      if (state_q == TAP_SHIR)      io_tdo = ir_lsb;
      else if (state_q == TAP_SHDR) io_tdo = io_chainIn_data;
   end

   assign io_bypass_sel = (io_instruction == BYPASS_INSTR);
   assign io_dbg_state  = state_q;

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Self-checking bench for jtag_tap_controller.
module tb_jtag_tap_controller;

   logic       clock;
   logic       reset;
   logic       io_tms;
   logic       io_tdi;
   logic       io_chainOut_capture;
   logic       io_chainOut_shift;
   logic       io_chainOut_update;
   logic       io_chainIn_data;
   logic [4:0] io_instruction;
   logic       io_tdo;
   logic       io_tdo_driven;
   logic       io_testLogicReset;
   logic       io_bypass_sel;
   logic [3:0] io_dbg_state;

   int checks = 0;
   int errors = 0;
   int cnt_cap, cnt_shift, cnt_upd;

   logic [3:0] model_st;
   logic [3:0] exp_q[$];
   logic       tdo_q[$];

   jtag_tap_controller dut (
      .clock               (clock),
      .reset               (reset),
      .io_tms              (io_tms),
      .io_tdi              (io_tdi),
      .io_chainOut_capture (io_chainOut_capture),
      .io_chainOut_shift   (io_chainOut_shift),
      .io_chainOut_update  (io_chainOut_update),
      .io_chainIn_data     (io_chainIn_data),
      .io_instruction      (io_instruction),
      .io_tdo              (io_tdo),
      .io_tdo_driven       (io_tdo_driven),
      .io_testLogicReset   (io_testLogicReset),
      .io_bypass_sel       (io_bypass_sel),
      .io_dbg_state        (io_dbg_state)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference next-state table (TMS=1 / TMS=0).
   function automatic logic [3:0] next_state(input logic [3:0] s, input logic tms);
      case (s)
         4'hF: return tms ? 4'hF : 4'hC;
         4'hC: return tms ? 4'h7 : 4'hC;
         4'h7: return tms ? 4'h4 : 4'h6;
         4'h6: return tms ? 4'h1 : 4'h2;
         4'h2: return tms ? 4'h1 : 4'h2;
         4'h1: return tms ? 4'h5 : 4'h3;
         4'h3: return tms ? 4'h0 : 4'h3;
         4'h0: return tms ? 4'h5 : 4'h2;
         4'h5: return tms ? 4'h7 : 4'hC;
         4'h4: return tms ? 4'hF : 4'hE;
         4'hE: return tms ? 4'h9 : 4'hA;
         4'hA: return tms ? 4'h9 : 4'hA;
         4'h9: return tms ? 4'hD : 4'hB;
         4'hB: return tms ? 4'h8 : 4'hB;
         4'h8: return tms ? 4'hD : 4'hA;
         default: return tms ? 4'hD : 4'hC;
      endcase
   endfunction

   // One TCK cycle: push expected state, clock, then compare all state-decoded outputs.
   task automatic tick(input logic tms, input logic tdi);
      logic [3:0] exp_st;
      io_tms   = tms;
      io_tdi   = tdi;
      model_st = next_state(model_st, tms);
      exp_q.push_back(model_st);
      @(posedge clock);
      #1;
      io_chainIn_data = 1'($urandom_range(0, 1));
      #1;
      exp_st = exp_q.pop_front();
      checks++;
      if (io_dbg_state !== exp_st) begin
         errors++;
         $display("FAIL state: got %h expected %h", io_dbg_state, exp_st);
      end
      checks++;
      if ({io_chainOut_capture, io_chainOut_shift, io_chainOut_update} !==
          {exp_st == 4'h6, exp_st == 4'h2, exp_st == 4'h5}) begin
         errors++;
         $display("FAIL strobes in %h: got cap/sh/up %b%b%b", exp_st,
                  io_chainOut_capture, io_chainOut_shift, io_chainOut_update);
      end
      checks++;
      if ($countones({io_chainOut_capture, io_chainOut_shift, io_chainOut_update}) > 1) begin
         errors++;
         $display("FAIL onehot: more than one strobe high in %h", exp_st);
      end
      checks++;
      if (io_tdo_driven !== (exp_st == 4'h2 || exp_st == 4'hA)) begin
         errors++;
         $display("FAIL tdo_driven in %h: got %b", exp_st, io_tdo_driven);
      end
      checks++;
      if (io_testLogicReset !== (exp_st == 4'hF)) begin
         errors++;
         $display("FAIL tlr in %h: got %b", exp_st, io_testLogicReset);
      end
      if (exp_st == 4'h2) begin
         checks++;
         if (io_tdo !== io_chainIn_data) begin
            errors++;
            $display("FAIL tdo_dr: got %b expected %b", io_tdo, io_chainIn_data);
         end
      end else if (exp_st != 4'hA) begin
         checks++;
         if (io_tdo !== 1'b0) begin
            errors++;
            $display("FAIL tdo_idle in %h: got %b expected 0", exp_st, io_tdo);
         end
      end
      if (exp_st == 4'h6) cnt_cap++;
      if (exp_st == 4'h2) cnt_shift++;
      if (exp_st == 4'h5) cnt_upd++;
   endtask

   task automatic check_instr(input string name, input logic [4:0] exp);
      checks++;
      if (io_instruction !== exp) begin
         errors++;
         $display("FAIL %s: instruction got %h expected %h", name, io_instruction, exp);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      io_tms = 1'b0; io_tdi = 1'b0; io_chainIn_data = 1'b0;
      model_st = 4'hF;
      #12;
      checks++;
      if ({io_dbg_state, io_chainOut_capture, io_chainOut_shift, io_chainOut_update,
           io_tdo, io_tdo_driven, io_testLogicReset} !== {4'hF, 6'b000001}) begin
         errors++;
         $display("FAIL reset_outputs: got st=%h c=%b s=%b u=%b tdo=%b drv=%b tlr=%b expected F/00000 1",
                  io_dbg_state, io_chainOut_capture, io_chainOut_shift, io_chainOut_update,
                  io_tdo, io_tdo_driven, io_testLogicReset);
      end
      check_instr("reset_instr", 5'h01);
      @(negedge clock);
      reset = 1'b1;
      tick(1'b0, 1'b0);
      check_instr("after_reset_instr", 5'h01);
   endtask

   // From RTI: full IR scan loading instr; TDO must show the captured 00001 pattern.
   task automatic test_ir_scan(input logic [4:0] instr, input logic [4:0] old_instr);
      tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tdo_q.push_back(1'b1);
      for (int i = 0; i < 4; i++) tdo_q.push_back(1'b0);
      tick(1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (io_dbg_state === 4'hA) begin
            if (io_tdo !== tdo_q[0]) begin
               errors++;
               $display("FAIL ir_tdo bit %0d: got %b expected %b", i, io_tdo, tdo_q[0]);
            end
         end else begin
            errors++;
            $display("FAIL ir_tdo bit %0d: not in ShIR (state %h)", i, io_dbg_state);
         end
         void'(tdo_q.pop_front());
         tick(i == 4, instr[i]);
      end
      tick(1'b1, 1'b0);
      check_instr("instr_held_in_updir", old_instr);
      tick(1'b0, 1'b0);
      check_instr("instr_after_updir", instr);
   endtask

   task automatic test_dr_scan();
      cnt_cap = 0; cnt_shift = 0; cnt_upd = 0;
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      checks++;
      if ({cnt_cap, cnt_shift, cnt_upd} !== {32'd1, 32'd9, 32'd1}) begin
         errors++;
         $display("FAIL dr_counts: got cap=%0d shift=%0d upd=%0d expected 1/9/1",
                  cnt_cap, cnt_shift, cnt_upd);
      end
   endtask

   task automatic test_pause();
      logic pat[6];
      pat = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      cnt_shift = 0;
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      foreach (pat[i]) tick(pat[i], 1'b0);
      checks++;
      if (cnt_shift !== 2) begin
         errors++;
         $display("FAIL pause_shift_count: got %0d expected 2", cnt_shift);
      end
   endtask

   task automatic test_tlr_from_shdr();
      tick(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) tick(1'b1, 1'b0);
      check_instr("tlr_not_yet", 5'h1F);
      tick(1'b1, 1'b0);
      checks++;
      if (io_testLogicReset !== 1'b1) begin
         errors++;
         $display("FAIL tlr_5x: got %b expected 1", io_testLogicReset);
      end
      check_instr("tlr_instr", 5'h01);
      checks++;
      if (io_bypass_sel !== 1'b0) begin
         errors++;
         $display("FAIL bypass_after_tlr: got %b expected 0", io_bypass_sel);
      end
   endtask

   task automatic test_async_reset_mid_shir();
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b1);
      #2;
      reset    = 1'b0;
      model_st = 4'hF;
      #1;
      checks++;
      if ({io_dbg_state, io_tdo_driven, io_testLogicReset} !== {4'hF, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL async_reset: got st=%h drv=%b tlr=%b expected F/0/1",
                  io_dbg_state, io_tdo_driven, io_testLogicReset);
      end
      check_instr("async_reset_instr", 5'h01);
      #1;
      reset = 1'b1;
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      check_instr("post_reset_instr", 5'h01);
   endtask

   initial begin
      test_reset();
      test_ir_scan(5'h1F, 5'h01);
      checks++;
      if (io_bypass_sel !== 1'b1) begin
         errors++;
         $display("FAIL bypass_sel: got %b expected 1", io_bypass_sel);
      end
      test_dr_scan();
      test_pause();
      test_tlr_from_shdr();
      tick(1'b0, 1'b0);
      test_ir_scan(5'h0A, 5'h01);
      test_async_reset_mid_shir();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
